// File: rtl/tff_sched_pkg.sv
// Shared definitions for the T flip-flop toggle scheduler.
//   state_e    : scheduler FSM states, fixed 2-bit encoding
//   DEF_NREQ   : default number of requesters
//   DEF_WIDTH  : default bank / mask width
package tff_sched_pkg;

  localparam int DEF_NREQ  = 4;
  localparam int DEF_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_APPLY  = 2'd1,
    ST_SETTLE = 2'd2,
    ST_REPORT = 2'd3
  } state_e;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker.
//   req_i : request vector
//   ptr_i : index with highest priority; search runs upward and wraps at N
//   gnt_o : one-hot grant (zero when no request)
//   idx_o : index of the granted request
//   any_o : at least one request present
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o,
  output logic          any_o
);

  logic [IW:0]   sum;
  logic [IW-1:0] cand;
  logic          found;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    sum   = '0;
    cand  = '0;
    for (int k = 0; k < N; k++) begin
      // ptr + k stays below 2N, so a single conditional subtract wraps it
      sum = {1'b0, ptr_i} + (IW+1)'(k);
      if (sum >= (IW+1)'(N)) sum = sum - (IW+1)'(N);
      cand = sum[IW-1:0];
      if (!found && req_i[cand]) begin
        found       = 1'b1;
        idx_o       = cand;
        gnt_o[cand] = 1'b1;
      end
    end
    any_o = found;
  end

endmodule

// File: rtl/tff_toggle_sched.sv
// Round-robin scheduler sharing one bank of WIDTH T flip-flops between NREQ
// requesters, with a priority clear that toggles every set bank bit back to 0.
//   clk, rst       : clock, asynchronous active-low reset
//   req_valid/ready: per-requester handshake; ready is one-hot or zero
//   req_mask       : flattened toggle masks, requester i owns [i*WIDTH +: WIDTH]
//   clr            : clear request, sampled only in IDLE
//   q_in           : bank state read back from the flip-flops
//   t_vec, t_stb   : bank T inputs and update strobe
//   done, done_clr, done_id, done_q : completion pulse and its result
//   busy           : high outside IDLE
module tff_toggle_sched
  import tff_sched_pkg::*;
#(
  parameter int NREQ  = DEF_NREQ,
  parameter int WIDTH = DEF_WIDTH,
  parameter int IDW   = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_mask,
  input  logic                  clr,
  input  logic [WIDTH-1:0]      q_in,
  output logic [WIDTH-1:0]      t_vec,
  output logic                  t_stb,
  output logic                  done,
  output logic                  done_clr,
  output logic [IDW-1:0]        done_id,
  output logic [WIDTH-1:0]      done_q,
  output logic                  busy
);

  state_e           state_q, state_d;
  logic [IDW-1:0]   ptr_q, ptr_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [IDW-1:0]   id_q, id_d;
  logic             clr_q, clr_d;
  logic [WIDTH-1:0] last_q_q, last_q_d;
  logic [IDW-1:0]   last_id_q, last_id_d;

  logic [NREQ-1:0]  pick_gnt;
  logic [IDW-1:0]   pick_idx;
  logic             pick_any;
  logic [WIDTH-1:0] mask_sel;

  rr_pick #(.N(NREQ), .IW(IDW)) u_pick (
    .req_i (req_valid),
    .ptr_i (ptr_q),
    .gnt_o (pick_gnt),
    .idx_o (pick_idx),
    .any_o (pick_any)
  );

  assign mask_sel = req_mask[pick_idx*WIDTH +: WIDTH];

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    mask_d    = mask_q;
    id_d      = id_q;
    clr_d     = clr_q;
    last_q_d  = last_q_q;
    last_id_d = last_id_q;
    req_ready = '0;
    t_stb     = 1'b0;
    t_vec     = '0;
    done      = 1'b0;
    done_clr  = 1'b0;
    done_id   = last_id_q;
    done_q    = last_q_q;
    busy      = (state_q != ST_IDLE);

    unique case (state_q)
      ST_IDLE: begin
        if (clr) begin
          // Toggling exactly the set bits drives the bank to all-zero
          mask_d  = q_in;
          id_d    = '0;
          clr_d   = 1'b1;
          state_d = (q_in != '0) ? ST_APPLY : ST_REPORT;
        end else if (pick_any) begin
          req_ready = pick_gnt;
          mask_d    = mask_sel;
          id_d      = pick_idx;
          clr_d     = 1'b0;
          state_d   = (mask_sel != '0) ? ST_APPLY : ST_REPORT;
        end
      end
      ST_APPLY: begin
        t_stb   = 1'b1;
        t_vec   = mask_q;
        state_d = ST_SETTLE;
      end
      ST_SETTLE: begin
        state_d = ST_REPORT;
      end
      ST_REPORT: begin
        done      = 1'b1;
        done_clr  = clr_q;
        done_id   = id_q;
        done_q    = q_in;
        last_q_d  = q_in;
        last_id_d = id_q;
        if (!clr_q) ptr_d = (id_q == IDW'(NREQ-1)) ? '0 : id_q + IDW'(1);
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // IDLE is also the reset state; keep the handshake quiet while reset is held
    if (!rst) req_ready = '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      ptr_q     <= '0;
      mask_q    <= '0;
      id_q      <= '0;
      clr_q     <= 1'b0;
      last_q_q  <= '0;
      last_id_q <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      mask_q    <= mask_d;
      id_q      <= id_d;
      clr_q     <= clr_d;
      last_q_q  <= last_q_d;
      last_id_q <= last_id_d;
    end
  end

endmodule

// File: tb/tb_tff_toggle_sched.sv
// Scoreboard bench for tff_toggle_sched with a behavioural T flip-flop bank.
module tb_tff_toggle_sched;

  localparam int NREQ  = 4;
  localparam int WIDTH = 8;
  localparam int IDW   = 2;

  logic                  clk = 1'b0;
  logic                  rst = 1'b0;
  logic [NREQ-1:0]       req_valid = '0;
  logic [NREQ*WIDTH-1:0] req_mask = '0;
  logic                  clr = 1'b0;
  logic [WIDTH-1:0]      bank = '0;
  logic [NREQ-1:0]       req_ready;
  logic [WIDTH-1:0]      t_vec;
  logic                  t_stb;
  logic                  done;
  logic                  done_clr;
  logic [IDW-1:0]        done_id;
  logic [WIDTH-1:0]      done_q;
  logic                  busy;

  tff_toggle_sched #(.NREQ(NREQ), .WIDTH(WIDTH), .IDW(IDW)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_mask  (req_mask),
    .clr       (clr),
    .q_in      (bank),
    .t_vec     (t_vec),
    .t_stb     (t_stb),
    .done      (done),
    .done_clr  (done_clr),
    .done_id   (done_id),
    .done_q    (done_q),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // The shared T flip-flop bank
  always @(posedge clk) if (t_stb) bank <= bank ^ t_vec;

  typedef struct { int id; int gap; } grant_t;
  typedef struct { bit c; int id; logic [WIDTH-1:0] q; int lat; } done_t;

  grant_t           exp_g[$];
  logic [WIDTH-1:0] exp_tv[$];
  done_t            exp_d[$];

  int checks = 0;
  int errors = 0;
  int prev_g = -100;
  int start_cyc = 0;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic push_g(int id, int gap);
    grant_t g;
    g.id = id; g.gap = gap;
    exp_g.push_back(g);
  endtask

  task automatic push_d(bit c, int id, logic [WIDTH-1:0] q, int lat);
    done_t d;
    d.c = c; d.id = id; d.q = q; d.lat = lat;
    exp_d.push_back(d);
  endtask

  task automatic wait_busy(logic v, string nm);
    for (int i = 0; i < 50; i++) begin
      @(posedge clk); #1;
      if (busy === v) return;
    end
    checks++;
    errors++;
    $display("FAIL %s timeout busy=%0b want %0b", nm, busy, v);
  endtask

  // Monitor: compares DUT activity against the scoreboard queues
  grant_t gm;
  done_t  dm;
  always @(negedge clk) begin
    if (rst) begin
      if (!busy && (|req_ready || clr)) start_cyc = cyc;
      if (|req_ready) begin
        chk("ready_only_idle", busy, 1'b0);
        if (exp_g.size() == 0) begin
          chk("unexpected_ready", req_ready, '0);
        end else begin
          gm = exp_g.pop_front();
          chk("grant", req_ready, 64'(1) << gm.id);
          if (gm.gap != 0) chk("grant_gap", cyc - prev_g, gm.gap);
        end
        prev_g = cyc;
      end
      if (t_stb) begin
        if (exp_tv.size() == 0) begin
          chk("unexpected_tstb", t_stb, 1'b0);
        end else begin
          chk("t_vec", t_vec, exp_tv.pop_front());
        end
      end else if (t_vec != '0) begin
        chk("t_vec_idle", t_vec, '0);
      end
      if (done) begin
        if (exp_d.size() == 0) begin
          chk("unexpected_done", done, 1'b0);
        end else begin
          dm = exp_d.pop_front();
          chk("done_clr", done_clr, dm.c);
          chk("done_id", done_id, dm.id);
          chk("done_q", done_q, dm.q);
          chk("done_latency", cyc - start_cyc, dm.lat);
        end
      end
    end
  end

  task automatic one_op(logic [NREQ-1:0] v, logic c, string nm);
    req_valid = v;
    clr = c;
    wait_busy(1'b1, nm);
    req_valid = '0;
    clr = 1'b0;
    wait_busy(1'b0, nm);
  endtask

  initial begin
    // Reset state, with requests pending to show ready stays low
    req_valid = 4'b1111;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs",
        {req_ready, t_stb, t_vec, done, done_clr, done_id, done_q, busy}, '0);
    req_valid = '0;
    rst = 1'b1;
    @(posedge clk); #1;

    // Single request from requester 2, bank 0x00
    req_mask[2*WIDTH +: WIDTH] = 8'h0F;
    push_g(2, 0); exp_tv.push_back(8'h0F); push_d(0, 2, 8'h0F, 3);
    one_op(4'b0100, 1'b0, "single");

    // Pointer is now 3: all valid must grant 3
    req_mask = {8'h80, 8'h40, 8'h20, 8'h10};
    push_g(3, 0); exp_tv.push_back(8'h80); push_d(0, 3, 8'h8F, 3);
    one_op(4'b1111, 1'b0, "ptr3");

    // Zero mask from requester 1: no strobe, done one cycle after accept
    req_mask[1*WIDTH +: WIDTH] = 8'h00;
    push_g(1, 0); push_d(0, 1, 8'h8F, 1);
    one_op(4'b0010, 1'b0, "zero_mask");

    // Bring the bank to 0xA5 via requester 2 (pointer 2 -> 3)
    req_mask[2*WIDTH +: WIDTH] = 8'h2A;
    push_g(2, 0); exp_tv.push_back(8'h2A); push_d(0, 2, 8'hA5, 3);
    one_op(4'b0100, 1'b0, "setup_a5");

    // Clear beats all requesters and leaves the pointer at 3
    exp_tv.push_back(8'hA5); push_d(1, 0, 8'h00, 3);
    one_op(4'b1111, 1'b1, "clear");

    req_mask = {8'h80, 8'h40, 8'h20, 8'h10};
    push_g(3, 0); exp_tv.push_back(8'h80); push_d(0, 3, 8'h80, 3);
    one_op(4'b1111, 1'b0, "after_clear");

    // Mask changed while busy is ignored; re-accept only after REPORT
    req_mask[1*WIDTH +: WIDTH] = 8'h03;
    push_g(1, 0); exp_tv.push_back(8'h03); push_d(0, 1, 8'h83, 3);
    push_g(1, 4); exp_tv.push_back(8'hFF); push_d(0, 1, 8'h7C, 3);
    req_valid = 4'b0010;
    wait_busy(1'b1, "ignore_acc");
    req_mask[1*WIDTH +: WIDTH] = 8'hFF;
    wait_busy(1'b0, "ignore_idle");
    wait_busy(1'b1, "ignore_reacc");
    req_valid = '0;
    wait_busy(1'b0, "ignore_end");

    // Reset during SETTLE abandons the operation
    req_mask[0 +: WIDTH] = 8'h01;
    push_g(0, 0); exp_tv.push_back(8'h01);
    req_valid = 4'b0001;
    wait_busy(1'b1, "midrst_acc");
    req_valid = 4'b1111;
    @(posedge clk); #1;
    chk("settle_busy", busy, 1'b1);
    #2 rst = 1'b0;
    #1;
    chk("midrst_outputs",
        {req_ready, t_stb, t_vec, done, done_clr, done_id, done_q, busy}, '0);
    req_valid = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;

    // Fairness from pointer 0, bank 0x7D
    req_mask = {8'h08, 8'h04, 8'h02, 8'h01};
    push_g(0, 0); exp_tv.push_back(8'h01); push_d(0, 0, 8'h7C, 3);
    push_g(1, 4); exp_tv.push_back(8'h02); push_d(0, 1, 8'h7E, 3);
    push_g(2, 4); exp_tv.push_back(8'h04); push_d(0, 2, 8'h7A, 3);
    push_g(3, 4); exp_tv.push_back(8'h08); push_d(0, 3, 8'h72, 3);
    push_g(0, 4); exp_tv.push_back(8'h01); push_d(0, 0, 8'h73, 3);
    req_valid = 4'b1111;
    for (int n = 0; n < 5; n++) begin
      wait_busy(1'b1, "fair_acc");
      if (n == 4) req_valid = '0;
      wait_busy(1'b0, "fair_idle");
    end

    repeat (3) @(posedge clk);
    #1;
    chk("queues_drained", exp_g.size() + exp_tv.size() + exp_d.size(), 0);
    chk("final_bank", bank, 8'h73);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
